// File: rtl/dac_frame_buffer_if.sv
// Sample-stream and DAC-side signals of the DAC frame buffer.
// in_data is taken on an edge where in_valid && in_ready; in_ready never depends on in_valid.
interface dac_frame_buffer_if;
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_ready;
   logic         dac_request;
   logic [127:0] dac_buffer;

   modport master (
      output in_data,
      output in_valid,
      output dac_request,
      input  in_ready,
      input  dac_buffer
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  dac_request,
      output in_ready,
      output dac_buffer
   );
endinterface

// File: rtl/dac_frame_buffer.sv
// Collects channel-interleaved sample words into four-channel frames, queues them in a FIFO
// and hands one frame to the DAC serializer per dac_request once the FIFO has been primed.
module dac_frame_buffer #(
   parameter int FIFO_DEPTH_LOG2 = 4,
   parameter int PRIME_LEVEL     = 2
) (
   input  logic                     capture_clk,
   input  logic                     reset,
   dac_frame_buffer_if.slave        bus,
   output logic [FIFO_DEPTH_LOG2:0] fill_level,
   output logic                     underrun,
   output logic [15:0]              underrun_count,
   output logic                     playing
);
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                     state;
   state_t                     state_next;
   logic [31:0]                stage0;
   logic [31:0]                stage1;
   logic [31:0]                stage2;
   logic [1:0]                 chan_idx;
   logic [127:0]               mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]              count;
   logic [CW-1:0]              count_next;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       accept;
   logic                       push;
   logic                       pop;
   logic                       under_evt;

   assign fifo_full  = (count == CW'(DEPTH));
   assign fifo_empty = (count == '0);

   // Only the frame-completing word can overflow, so earlier channels keep flowing when full.
   assign bus.in_ready = !reset && !(fifo_full && (chan_idx == 2'd3));
   assign accept       = bus.in_valid && bus.in_ready;
   assign push         = accept && (chan_idx == 2'd3);

   // The pop decision uses the registered count: a frame completing this cycle is not bypassed.
   assign pop       = (state == RUN) && bus.dac_request && !fifo_empty;
   assign under_evt = (state == RUN) && bus.dac_request && fifo_empty;

   assign fill_level = count;
   assign playing    = (state == RUN);

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Priming looks at the next count so playing rises together with fill_level.
   always_comb begin
      state_next = state;
      case (state)
         PRIME: if (count_next >= CW'(PRIME_LEVEL)) state_next = RUN;
         RUN:   state_next = RUN;
         default: state_next = PRIME;
      endcase
   end

   always_ff @(posedge capture_clk) begin
      if (reset) begin
         state <= PRIME;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge capture_clk) begin
      if (reset) begin
         chan_idx <= 2'd0;
      end else if (accept) begin
         chan_idx <= chan_idx + 2'd1;
      end
   end

   always_ff @(posedge capture_clk) begin
      if (accept) begin
         case (chan_idx)
            2'd0:    stage0 <= bus.in_data;
            2'd1:    stage1 <= bus.in_data;
            2'd2:    stage2 <= bus.in_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge capture_clk) begin
      if (push) begin
         mem[wr_ptr] <= {bus.in_data, stage2, stage1, stage0};
      end
   end

   always_ff @(posedge capture_clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
      end
   end

   // On an underrun the previous frame is simply left in place.
   always_ff @(posedge capture_clk) begin
      if (reset) begin
         bus.dac_buffer <= '0;
      end else if (pop) begin
         bus.dac_buffer <= mem[rd_ptr];
      end
   end

   always_ff @(posedge capture_clk) begin
      if (reset) begin
         underrun       <= 1'b0;
         underrun_count <= 16'd0;
      end else if (under_evt) begin
         underrun <= 1'b1;
         if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
      end
   end
endmodule

// File: doc/dac_frame_buffer.md
DAC_FRAME_BUFFER -- requirements
Module: dac_frame_buffer

Interface
Parameters:
REQ-001 The block SHALL have parameter FIFO_DEPTH_LOG2, default 4, meaning FIFO depth of 2**FIFO_DEPTH_LOG2 four-channel frames.
REQ-002 The block SHALL have parameter PRIME_LEVEL, default 2, meaning the minimum number of frames held before playback starts (1..FIFO depth).

Ports:
REQ-003 The block SHALL have port capture_clk  input  1  data acquisition clock (SYSCLK/4); sole clock.
REQ-004 The block SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port in_data  input  32  sample word; channel-interleaved ch0,ch1,ch2,ch3.
REQ-006 The block SHALL have port in_valid  input  1  in_data valid.
REQ-007 The block SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 The block SHALL have port dac_request  input  1  single-cycle pulse from the DAC serializer requesting the next frame.
REQ-009 The block SHALL have port dac_buffer  output  128  current frame; channel n at bits [32n+31:32n].
REQ-010 The block SHALL have port fill_level  output  FIFO_DEPTH_LOG2+1  number of complete frames in the FIFO.
REQ-011 The block SHALL have port underrun  output  1  sticky flag, set on any underrun.
REQ-012 The block SHALL have port underrun_count  output  16  saturating underrun counter.
REQ-013 The block SHALL have port playing  output  1  high in state RUN.

Function
REQ-014 A word SHALL be accepted on a capture_clk edge where in_valid and in_ready are both high.
REQ-015 Accepted words SHALL be written into a staging register at index chan_idx (0..3); chan_idx SHALL increment and wrap 3->0.
- Frame push:
REQ-016 Accepting the word with chan_idx==3 SHALL push {word, stage[2], stage[1], stage[0]} into the FIFO as one frame.
REQ-017 in_ready SHALL equal NOT(fifo_full AND chan_idx==3) while reset is low, so that a frame never overflows.
- Frame pop:
REQ-018 A frame SHALL be popped only in state RUN, on a cycle where dac_request is high and fill_level>0.
REQ-019 A popped frame SHALL appear on dac_buffer on the cycle after the dac_request (1-cycle latency).
REQ-020 dac_buffer SHALL otherwise hold its value.
REQ-021 A push and a pop in the same cycle SHALL leave fill_level unchanged.
REQ-022 With an empty FIFO, a same-cycle push SHALL NOT be bypassed to the pop: the pop is treated as an underrun.
- FSM:
REQ-023 The block SHALL have two states, PRIME and RUN.
REQ-024 PRIME->RUN SHALL occur when fill_level>=PRIME_LEVEL.
REQ-025 In PRIME, dac_request SHALL be ignored: no pop, no underrun, and dac_buffer stays 0.
REQ-026 RUN SHALL be left only by reset.
- Underrun:
REQ-027 An underrun SHALL be a dac_request in RUN with fill_level==0.
REQ-028 On an underrun, dac_buffer SHALL hold the previous frame.
REQ-029 On an underrun, underrun SHALL be set to 1 and underrun_count SHALL be incremented, saturating at 16'hFFFF.
- Storage and arithmetic:
REQ-030 FIFO read and write pointers SHALL be FIFO_DEPTH_LOG2 bits wide and wrap modulo the FIFO depth.
REQ-031 fill_level SHALL be the registered count (0..2**FIFO_DEPTH_LOG2), with full at the maximum and empty at 0.
REQ-032 Sample words SHALL pass unmodified; any 24-bit truncation is the downstream block's responsibility.

Reset
REQ-033 While reset is high at a capture_clk edge, dac_buffer, fill_level, underrun, underrun_count and playing SHALL all be 0 on the next cycle.
REQ-034 While reset is high, in_ready SHALL be 0, chan_idx SHALL be 0, both FIFO pointers SHALL be 0, and the state SHALL be PRIME.
REQ-035 Reset mid-frame SHALL discard the staged words and all FIFO contents; the next accepted word is ch0.
REQ-036 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-037 Prime: after reset, push 1 frame (words 1..4) and pulse dac_request -> dac_buffer stays 0, underrun=0, playing=0; push a second frame -> playing=1 on the cycle fill_level reaches 2.
REQ-038 Order/latency: frames A=(1,2,3,4) and B=(5,6,7,8) queued in RUN; dac_request at cycle t -> dac_buffer={4,3,2,1} at t+1; next request -> {8,7,6,5}; fill_level decrements on each pop.
REQ-039 Full: with FIFO_DEPTH_LOG2=2 and no requests, stream 16 words -> fill_level=4; words 17-19 accepted; in_ready=0 at chan_idx==3; one dac_request -> in_ready=1 the next cycle and the 20th word completes the frame.
REQ-040 Underrun: in RUN, drain the FIFO then issue 3 requests -> dac_buffer holds the last frame, underrun=1, underrun_count=3; a later push and pop resumes with underrun still 1.
REQ-041 Simultaneous events: on fill_level==0 in RUN, complete a frame on the same cycle as dac_request -> underrun counted, fill_level=1 next cycle; with fill_level=2, push and pop on the same cycle -> fill_level stays 2.
REQ-042 Mid-operation reset: assert reset after 2 words of a frame with 3 frames queued -> all outputs 0, PRIME state; words 9..12 then form channels 0..3 of the next frame.
